// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit.
//   mdu_op_e     : operation encodings as driven on the op port
//   mdu_state_e  : sequencer states (IDLE -> CALC -> FIX -> IDLE)
//   MDU_WIDTH    : default operand width
//   CNT_W        : iteration counter width; one iteration per operand bit
//   op_is_signed : true for the two's-complement operations
package mdu_pkg;

  localparam int MDU_WIDTH = 32;
  localparam int CNT_W     = $clog2(MDU_WIDTH);

  typedef enum logic [1:0] {
    MDU_MULT  = 2'd0,
    MDU_MULTU = 2'd1,
    MDU_DIV   = 2'd2,
    MDU_DIVU  = 2'd3
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } mdu_state_e;

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

endpackage

// File: rtl/mdu_negate.sv
// Conditional two's-complement negate.
//   en : negate when high, pass through when low
//   a  : WIDTH-bit input
//   y  : a or -a
// Used both to take operand magnitudes and to restore result signs.
module mdu_negate #(
  parameter int WIDTH = 32
) (
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y
);

  assign y = en ? (~a + WIDTH'(1)) : a;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit holding the HI/LO pair.
//   clk, rst_n        : rising-edge clock, asynchronous active-low reset
//   start, op         : launch MULT/MULTU/DIV/DIVU (accepted only when idle)
//   input1, input2    : multiplicand/dividend, multiplier/divisor
//   mthi, mtlo        : direct HI/LO writes with hi_wdata/lo_wdata (idle only)
//   busy              : operation in flight; start/mthi/mtlo ignored
//   done              : one-cycle pulse when HI/LO carry a fresh result
//   dz                : last division had a zero divisor
//   hi, lo            : HI/LO registers
// An op takes WIDTH CALC cycles (one bit each) plus one FIX cycle that
// restores signs and writes HI/LO; done follows 34 cycles after start.
// CNT_W comes from the package, so WIDTH must not exceed 2**CNT_W.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] hi_wdata,
  input  logic [WIDTH-1:0] lo_wdata,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             done_q;
  logic             dz_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  logic             accept;
  logic             last_iter;
  logic             sgn;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  logic             is_div_p0;
  logic             neg_res_p0;
  logic             neg_rem_p0;
  logic             dz_p0;
  logic [WIDTH-1:0] a_raw_p0;
  logic [WIDTH-1:0] step_p0;

  logic [2*WIDTH-1:0] acc_p1;
  logic [WIDTH-1:0]   rem_p1;
  logic [WIDTH-1:0]   quo_p1;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH:0]     rem_shift;
  logic               rem_ge;
  logic [WIDTH-1:0]   rem_nxt;
  logic [WIDTH-1:0]   quo_nxt;

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign accept    = (state_q == IDLE) && start;
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));
  assign sgn       = op_is_signed(op);

  // ---- stage p0: operand magnitudes and sign bookkeeping at launch ----
  mdu_negate #(.WIDTH(WIDTH)) u_neg_a (
    .en (sgn & input1[WIDTH-1]),
    .a  (input1),
    .y  (a_mag)
  );

  mdu_negate #(.WIDTH(WIDTH)) u_neg_b (
    .en (sgn & input2[WIDTH-1]),
    .a  (input2),
    .y  (b_mag)
  );

  // ---- stage p1: one multiplier bit / one quotient bit per CALC cycle ----
  // Multiply: the low half of acc starts as the multiplier and is shifted
  // out as product bits shift in; the carry rides into the top bit.
  assign mul_sum = {1'b0, acc_p1[2*WIDTH-1:WIDTH]} +
                   (acc_p1[0] ? {1'b0, step_p0} : {(WIDTH+1){1'b0}});
  assign acc_nxt = {mul_sum, acc_p1[WIDTH-1:1]};

  // Restoring divide: the shifted partial remainder needs WIDTH+1 bits so a
  // dividend MSB of 1 cannot be lost before the trial subtraction.
  assign rem_shift = {rem_p1, quo_p1[WIDTH-1]};
  assign rem_ge    = (rem_shift >= {1'b0, step_p0});
  assign rem_nxt   = rem_ge ? WIDTH'(rem_shift - {1'b0, step_p0})
                            : rem_shift[WIDTH-1:0];
  assign quo_nxt   = {quo_p1[WIDTH-2:0], rem_ge};

  always_ff @(posedge clk) begin
    if (accept) begin
      is_div_p0  <= op[1];
      neg_res_p0 <= sgn & (input1[WIDTH-1] ^ input2[WIDTH-1]);
      neg_rem_p0 <= sgn & input1[WIDTH-1];
      dz_p0      <= op[1] & (input2 == '0);
      a_raw_p0   <= input1;
      // The shared step operand is the multiplicand or the divisor.
      step_p0    <= op[1] ? b_mag : a_mag;
      acc_p1     <= {{WIDTH{1'b0}}, b_mag};
      rem_p1     <= '0;
      quo_p1     <= a_mag;
    end else if (state_q == CALC) begin
      acc_p1 <= acc_nxt;
      rem_p1 <= rem_nxt;
      quo_p1 <= quo_nxt;
    end
  end

  // ---- stage p2: sign fix-up and HI/LO write in FIX ----
  mdu_negate #(.WIDTH(2*WIDTH)) u_neg_prod (
    .en (neg_res_p0),
    .a  (acc_p1),
    .y  (prod_fix)
  );

  mdu_negate #(.WIDTH(WIDTH)) u_neg_quo (
    .en (neg_res_p0),
    .a  (quo_p1),
    .y  (quo_fix)
  );

  mdu_negate #(.WIDTH(WIDTH)) u_neg_rem (
    .en (neg_rem_p0),
    .a  (rem_p1),
    .y  (rem_fix)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = CALC;
      CALC:    if (last_iter) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == FIX);

      if (accept) begin
        cnt_q <= '0;
      end else if (state_q == CALC) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end

      if (accept) begin
        dz_q <= 1'b0;
      end else if (state_q == FIX) begin
        dz_q <= dz_p0;
      end

      if (state_q == FIX) begin
        if (!is_div_p0) begin
          hi_q <= prod_fix[2*WIDTH-1:WIDTH];
          lo_q <= prod_fix[WIDTH-1:0];
        end else if (dz_p0) begin
          // Zero divisor: fixed pattern, no sign restoration.
          hi_q <= a_raw_p0;
          lo_q <= '1;
        end else begin
          hi_q <= rem_fix;
          lo_q <= quo_fix;
        end
      end else if (state_q == IDLE) begin
        if (mthi) hi_q <= hi_wdata;
        if (mtlo) lo_q <= lo_wdata;
      end
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign dz   = dz_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: a transaction-level reference (plain 64-bit
// arithmetic plus a cycle countdown) is compared with the DUT outputs on
// every falling edge; directed scenarios add literal expectations.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] input1 = '0;
  logic [31:0] input2 = '0;
  logic        mthi = 1'b0;
  logic        mtlo = 1'b0;
  logic [31:0] hi_wdata = '0;
  logic [31:0] lo_wdata = '0;
  logic        busy;
  logic        done;
  logic        dz;
  logic [31:0] hi;
  logic [31:0] lo;

  always #5 clk = ~clk;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .input1   (input1),
    .input2   (input2),
    .mthi     (mthi),
    .mtlo     (mtlo),
    .hi_wdata (hi_wdata),
    .lo_wdata (lo_wdata),
    .busy     (busy),
    .done     (done),
    .dz       (dz),
    .hi       (hi),
    .lo       (lo)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%h required=%h at %0t", nm, act, req, $time);
    end
  endtask

  // Reference arithmetic: results straight from the operation definitions.
  function automatic void ref_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] rh, output logic [31:0] rl, output logic rdz);
    longint      p, q, r;
    logic [63:0] u;
    rdz = 1'b0;
    u   = '0;
    case (o)
      2'd0: begin
        p = longint'($signed(a)) * longint'($signed(b));
        u = p;
      end
      2'd1: u = {32'd0, a} * {32'd0, b};
      2'd2: begin
        if (b == 32'd0) begin
          rdz = 1'b1;
          u   = {a, 32'hFFFFFFFF};
        end else begin
          q = longint'($signed(a)) / longint'($signed(b));
          r = longint'($signed(a)) % longint'($signed(b));
          u = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 32'd0) begin
          rdz = 1'b1;
          u   = {a, 32'hFFFFFFFF};
        end else begin
          u = {a % b, a / b};
        end
      end
    endcase
    rh = u[63:32];
    rl = u[31:0];
  endfunction

  // Behavioural model: idle/busy with a countdown of 33 edges per op.
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic        m_dz = 1'b0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  int          m_left = 0;
  logic [31:0] r_hi = '0;
  logic [31:0] r_lo = '0;
  logic        r_dz = 1'b0;
  logic [31:0] t_hi, t_lo;
  logic        t_dz;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_dz   <= 1'b0;
      m_hi   <= '0;
      m_lo   <= '0;
      m_left <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_hi   <= r_hi;
          m_lo   <= r_lo;
          m_dz   <= r_dz;
          m_done <= 1'b1;
          m_busy <= 1'b0;
        end
      end else begin
        if (mthi) m_hi <= hi_wdata;
        if (mtlo) m_lo <= lo_wdata;
        if (start) begin
          ref_op(op, input1, input2, t_hi, t_lo, t_dz);
          r_hi   <= t_hi;
          r_lo   <= t_lo;
          r_dz   <= t_dz;
          m_left <= 33;
          m_busy <= 1'b1;
          m_dz   <= 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", {31'd0, busy}, {31'd0, m_busy});
      chk("done", {31'd0, done}, {31'd0, m_done});
      chk("dz",   {31'd0, dz},   {31'd0, m_dz});
      chk("hi",   hi, m_hi);
      chk("lo",   lo, m_lo);
    end
  end

  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op     = o;
    input1 = a;
    input2 = b;
    start  = 1'b1;
  endtask

  // Waits (bounded) for done; cyc counts falling edges after the launch edge.
  // With inj set, a conflicting start plus mthi is pulsed at cycle 5.
  task automatic wait_done(input bit inj, output int cyc);
    cyc = 0;
    while (cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        start  = 1'b0;
        op     = 2'($urandom);
        input1 = $urandom;
        input2 = $urandom;
      end
      if (inj && cyc == 5) begin
        launch(2'd3, 32'd5, 32'd0);
        mthi     = 1'b1;
        hi_wdata = 32'hDEADBEEF;
      end
      if (inj && cyc == 6) begin
        start = 1'b0;
        mthi  = 1'b0;
      end
      if (inj && cyc == 8) chk("mthi ignored while busy", hi, 32'd2);
      if (done) break;
    end
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h80000000;
      2:       return 32'hFFFFFFFF;
      3:       return 32'($urandom_range(1, 15));
      4:       return -32'($urandom_range(1, 15));
      default: return $urandom;
    endcase
  endfunction

  int cyc;
  int n_done;

  initial begin
    // Pin the reference arithmetic to hand-computed values.
    ref_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, t_hi, t_lo, t_dz);
    chk("model multu hi", t_hi, 32'hFFFFFFFE);
    chk("model multu lo", t_lo, 32'h00000001);
    ref_op(2'd0, 32'hFFFFFFFD, 32'd7, t_hi, t_lo, t_dz);
    chk("model mult lo", t_lo, 32'hFFFFFFEB);
    ref_op(2'd2, 32'hFFFFFFF9, 32'd2, t_hi, t_lo, t_dz);
    chk("model div hi", t_hi, 32'hFFFFFFFF);
    chk("model div lo", t_lo, 32'hFFFFFFFD);
    ref_op(2'd2, 32'h80000000, 32'hFFFFFFFF, t_hi, t_lo, t_dz);
    chk("model div wrap lo", t_lo, 32'h80000000);
    ref_op(2'd0, 32'h80000000, 32'h80000000, t_hi, t_lo, t_dz);
    chk("model mult min hi", t_hi, 32'h40000000);
    ref_op(2'd3, 32'd100, 32'd0, t_hi, t_lo, t_dz);
    chk("model divu dz", {31'd0, t_dz}, 32'd1);
    chk("model divu dz hi", t_hi, 32'd100);

    repeat (3) @(negedge clk);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset hi", hi, 32'd0);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("idle done", {31'd0, done}, 32'd0);
    chk("idle dz", {31'd0, dz}, 32'd0);
    chk("idle lo", lo, 32'd0);

    // MULTU of two all-ones operands and start->done latency.
    launch(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(1'b0, cyc);
    chk("multu latency", 32'(cyc), 32'd34);
    chk("multu busy in done cycle", {31'd0, busy}, 32'd0);
    chk("multu hi", hi, 32'hFFFFFFFE);
    chk("multu lo", lo, 32'h00000001);
    chk("multu dz", {31'd0, dz}, 32'd0);

    // Signed multiply and divide, each launched in the previous done cycle.
    launch(2'd0, 32'hFFFFFFFD, 32'd7);
    wait_done(1'b0, cyc);
    chk("mult latency", 32'(cyc), 32'd34);
    chk("mult hi", hi, 32'hFFFFFFFF);
    chk("mult lo", lo, 32'hFFFFFFEB);
    launch(2'd2, 32'hFFFFFFF9, 32'd2);
    wait_done(1'b0, cyc);
    chk("div lo", lo, 32'hFFFFFFFD);
    chk("div hi", hi, 32'hFFFFFFFF);

    // Divide by zero, then dz clears as the next op is accepted.
    launch(2'd3, 32'd100, 32'd0);
    wait_done(1'b0, cyc);
    chk("divu0 latency", 32'(cyc), 32'd34);
    chk("divu0 dz", {31'd0, dz}, 32'd1);
    chk("divu0 lo", lo, 32'hFFFFFFFF);
    chk("divu0 hi", hi, 32'd100);
    launch(2'd3, 32'd100, 32'd7);
    @(negedge clk);
    start = 1'b0;
    chk("dz cleared at start", {31'd0, dz}, 32'd0);
    wait_done(1'b0, cyc);
    chk("divu latency", 32'(cyc), 32'd33);
    chk("divu lo", lo, 32'd14);
    chk("divu hi", hi, 32'd2);

    // Conflicting start and mthi while busy are ignored.
    @(negedge clk);
    launch(2'd1, 32'h00010000, 32'h00030000);
    wait_done(1'b1, cyc);
    chk("busy-start latency", 32'(cyc), 32'd34);
    chk("busy-start hi", hi, 32'd3);
    chk("busy-start lo", lo, 32'd0);
    chk("busy-start dz", {31'd0, dz}, 32'd0);

    // Reset in the middle of a MULT.
    @(negedge clk);
    launch(2'd0, 32'h12345678, 32'hFFFF0001);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midop reset busy", {31'd0, busy}, 32'd0);
    chk("midop reset hi", hi, 32'd0);
    chk("midop reset lo", lo, 32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    n_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) n_done++;
    end
    chk("no done after reset", 32'(n_done), 32'd0);

    // MULT of the most negative value with itself, then DIV wrap back-to-back.
    launch(2'd0, 32'h80000000, 32'h80000000);
    wait_done(1'b0, cyc);
    chk("mult min hi", hi, 32'h40000000);
    chk("mult min lo", lo, 32'd0);
    launch(2'd2, 32'h80000000, 32'hFFFFFFFF);
    wait_done(1'b0, cyc);
    chk("div wrap latency", 32'(cyc), 32'd34);
    chk("div wrap lo", lo, 32'h80000000);
    chk("div wrap hi", hi, 32'd0);
    chk("div wrap dz", {31'd0, dz}, 32'd0);

    // Random traffic: starts, mthi/mtlo and operand churn every cycle.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start    = ($urandom_range(0, 7) == 0);
      op       = 2'($urandom);
      input1   = rnd_operand();
      input2   = rnd_operand();
      mthi     = ($urandom_range(0, 9) == 0);
      mtlo     = ($urandom_range(0, 9) == 0);
      hi_wdata = $urandom;
      lo_wdata = $urandom;
    end
    @(negedge clk);
    start = 1'b0;
    mthi  = 1'b0;
    mtlo  = 1'b0;
    repeat (40) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
